adc_capture: RTL and testbench



---
 rtl/adc_pkg.sv | 27 ++
 rtl/adc_clk_div.sv | 56 +++++
 rtl/adc_capture.sv | 188 ++++++++++++++++++
 tb/tb_adc_capture.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_pkg.sv
// adc_pkg -- shared types and helpers for the ADC capture front end.
//
// Contents:
//   cap_state_e  capture FSM states (IDLE, WARM, RUN)
//   ADC_DATA_W   native ADC code width; adc_capture's DATA_W defaults to it
//   CODE_ZERO    bottom rail code (all zeros)
//   CODE_ONES    top rail code (all ones)
//   ob2tc()      offset-binary to two's-complement conversion (MSB invert)
package adc_pkg;

    localparam int ADC_DATA_W = 8;

    localparam logic [ADC_DATA_W-1:0] CODE_ZERO = '0;
    localparam logic [ADC_DATA_W-1:0] CODE_ONES = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WARM = 2'd1,
        RUN  = 2'd2
    } cap_state_e;

    // Offset-binary code c maps to c - 2**(W-1); flipping the MSB does exactly that.
    function automatic logic signed [ADC_DATA_W-1:0] ob2tc(input logic [ADC_DATA_W-1:0] code);
        return {~code[ADC_DATA_W-1], code[ADC_DATA_W-2:0]};
    endfunction

endpackage

// File: rtl/adc_clk_div.sv
// adc_clk_div -- divides clk down to the ADC sample clock and marks the
// capture cycle.
//
// Parameters:
//   DIV        system clocks per ADC sample (2..65535)
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   clr_i      synchronous clear; holds the divider at 0 and adc_clk low
//   cap_stb_o  high on the cycle div_cnt == DIV-1 (the capture cycle)
//   adc_clk_o  registered ADC clock, high while div_cnt < DIV/2
module adc_clk_div #(
    parameter int DIV = 50
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    output logic cap_stb_o,
    output logic adc_clk_o
);

    localparam int                CNT_W    = $clog2(DIV);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0]  CNT_HALF = CNT_W'(DIV / 2);

    logic [CNT_W-1:0] div_cnt_q, div_cnt_d;
    logic             adc_clk_q, adc_clk_d;

    always_comb begin
        div_cnt_d = div_cnt_q;
        adc_clk_d = 1'b0;
        if (clr_i) begin
            div_cnt_d = '0;
        end else begin
            // adc_clk is the registered image of the current count, so the
            // pin shows a clean DIV/2 high, DIV-DIV/2 low waveform one clk
            // behind div_cnt.
            adc_clk_d = (div_cnt_q < CNT_HALF);
            div_cnt_d = (div_cnt_q == CNT_LAST) ? '0 : div_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q <= '0;
            adc_clk_q <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            adc_clk_q <= adc_clk_d;
        end
    end

    assign cap_stb_o = !clr_i && (div_cnt_q == CNT_LAST);
    assign adc_clk_o = adc_clk_q;

endmodule

// File: rtl/adc_capture.sv
// adc_capture -- ADC front end: generates the ADC sample clock, captures
// offset-binary codes, drops start-up samples after each enable and presents
// two's-complement samples with a one-cycle valid strobe. Flags over-range
// (code at either rail) with a sticky flag.
//
// Optional feature macro: ADC_AVG2_EN
//   defined   : RUN samples are averaged in pairs, (s0+s1)>>>1, one strobe per pair
//   undefined : every RUN sample is output
//
// Parameters:
//   DATA_W   ADC/sample width (tied to adc_pkg::ADC_DATA_W)
//   DIV      system clocks per ADC sample (2..65535)
//   DISCARD  samples dropped after each enable (0 allowed)
// Ports:
//   clk       system clock
//   rst_n     asynchronous active-low reset
//   en        capture enable, level-sensitive
//   adc_data  raw ADC code, unsigned offset-binary
//   ovr_clr   single-cycle clear of the sticky over-range flag
//   adc_clk   registered clock to the ADC
//   smp_out   signed two's-complement sample, held between strobes
//   smp_vld   one-cycle strobe, smp_out is new on this cycle
//   ovr       sticky over-range flag
module adc_capture
    import adc_pkg::*;
#(
    parameter int DATA_W  = ADC_DATA_W,
    parameter int DIV     = 50,
    parameter int DISCARD = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic [DATA_W-1:0]        adc_data,
    input  logic                     ovr_clr,
    output logic                     adc_clk,
    output logic signed [DATA_W-1:0] smp_out,
    output logic                     smp_vld,
    output logic                     ovr
);

    localparam int DISC_W = (DISCARD < 1) ? 1 : $clog2(DISCARD + 1);

    cap_state_e               state_q, state_d;
    logic [DISC_W-1:0]        disc_cnt_q, disc_cnt_d;
    logic signed [DATA_W-1:0] smp_out_q, smp_out_d;
    logic                     smp_vld_q, smp_vld_d;
    logic                     ovr_q, ovr_d;
    logic                     rail_q, rail_d;

    logic                     cap_stb;
    logic                     run_cap;
    logic                     is_rail;
    logic signed [DATA_W-1:0] sample_tc;

`ifdef ADC_AVG2_EN
    logic                     pair_q, pair_d;
    logic signed [DATA_W-1:0] s0_q, s0_d;

    // One extra bit of headroom makes the sum exact; dropping its LSB is a
    // floor divide by two.
    function automatic logic signed [DATA_W-1:0] avg2(input logic signed [DATA_W-1:0] a,
                                                      input logic signed [DATA_W-1:0] b);
        logic signed [DATA_W:0] sum;
        sum = {a[DATA_W-1], a} + {b[DATA_W-1], b};
        return sum[DATA_W:1];
    endfunction
`endif

    // The FSM falls to IDLE in exactly the cycles en is low, so !en is the
    // "next state is IDLE" clear for the divider.
    adc_clk_div #(
        .DIV (DIV)
    ) u_div (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_i     (!en),
        .cap_stb_o (cap_stb),
        .adc_clk_o (adc_clk)
    );

    assign run_cap   = cap_stb && (state_q == RUN);
    assign is_rail   = (adc_data == CODE_ZERO) || (adc_data == CODE_ONES);
    assign sample_tc = ob2tc(adc_data);

    always_comb begin
        state_d    = state_q;
        disc_cnt_d = disc_cnt_q;
        if (!en) begin
            state_d    = IDLE;
            disc_cnt_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (DISCARD == 0) begin
                        state_d = RUN;
                    end else begin
                        state_d    = WARM;
                        disc_cnt_d = DISC_W'(DISCARD);
                    end
                end
                WARM: begin
                    if (cap_stb) begin
                        disc_cnt_d = disc_cnt_q - DISC_W'(1);
                        if (disc_cnt_q == DISC_W'(1)) begin
                            state_d = RUN;
                        end
                    end
                end
                RUN:     state_d = RUN;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        smp_out_d = smp_out_q;
        smp_vld_d = 1'b0;
        ovr_d     = ovr_q;
        rail_d    = run_cap && is_rail;
`ifdef ADC_AVG2_EN
        pair_d = pair_q;
        s0_d   = s0_q;
        // Outside RUN the pair restarts, so the first RUN sample is always s0.
        if (state_q != RUN) begin
            pair_d = 1'b0;
        end
        if (run_cap) begin
            if (!pair_q) begin
                s0_d   = sample_tc;
                pair_d = 1'b1;
            end else begin
                smp_out_d = avg2(s0_q, sample_tc);
                smp_vld_d = 1'b1;
                pair_d    = 1'b0;
            end
        end
`else
        if (run_cap) begin
            smp_out_d = sample_tc;
            smp_vld_d = 1'b1;
        end
`endif
        // A rail sample's set covers both its capture edge and the following
        // strobe cycle, so a clear landing on either is overridden.
        if (ovr_clr && !rail_q) begin
            ovr_d = 1'b0;
        end
        if (rail_d) begin
            ovr_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            disc_cnt_q <= '0;
            smp_out_q  <= '0;
            smp_vld_q  <= 1'b0;
            ovr_q      <= 1'b0;
            rail_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            disc_cnt_q <= disc_cnt_d;
            smp_out_q  <= smp_out_d;
            smp_vld_q  <= smp_vld_d;
            ovr_q      <= ovr_d;
            rail_q     <= rail_d;
        end
    end

`ifdef ADC_AVG2_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pair_q <= 1'b0;
            s0_q   <= '0;
        end else begin
            pair_q <= pair_d;
            s0_q   <= s0_d;
        end
    end
`endif

    assign smp_out = smp_out_q;
    assign smp_vld = smp_vld_q;
    assign ovr     = ovr_q;

endmodule

// File: tb/tb_adc_capture.sv
module tb_adc_capture;

    localparam int DATA_W  = 8;
    localparam int DIV     = 50;
    localparam int DISCARD = 4;
`ifdef ADC_AVG2_EN
    localparam int GRP = 2;
`else
    localparam int GRP = 1;
`endif
    localparam int FIRST_LAT = DIV * (DISCARD + GRP);
    localparam int STRB_GAP  = DIV * GRP;

    logic                     clk;
    logic                     rst_n;
    logic                     en;
    logic [DATA_W-1:0]        adc_data;
    logic                     ovr_clr;
    logic                     adc_clk;
    logic signed [DATA_W-1:0] smp_out;
    logic                     smp_vld;
    logic                     ovr;

    int checks = 0;
    int errors = 0;

    adc_capture #(
        .DATA_W  (DATA_W),
        .DIV     (DIV),
        .DISCARD (DISCARD)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .adc_data (adc_data),
        .ovr_clr  (ovr_clr),
        .adc_clk  (adc_clk),
        .smp_out  (smp_out),
        .smp_vld  (smp_vld),
        .ovr      (ovr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: k counts enabled cycles since en rose (k=0 is the first
    // enabled cycle). Sample n is captured at the end of cycle n*DIV+DIV-1;
    // samples n >= DISCARD are RUN samples and strobe on the next cycle.
    int m_k;
    int m_out;
    int m_s0;
    bit m_vld, m_ovr, m_aclk, m_set_prev;

    always @(posedge clk or negedge rst_n) begin : model
        bit set_now;
        int r, v;
        if (!rst_n) begin
            m_k = 0; m_out = 0; m_s0 = 0;
            m_vld = 0; m_ovr = 0; m_aclk = 0; m_set_prev = 0;
        end else begin
            set_now = 0;
            m_vld   = 0;
            if (en) begin
                m_aclk = (m_k % DIV) < (DIV / 2);
                if ((m_k % DIV == DIV - 1) && (m_k / DIV >= DISCARD)) begin
                    r = m_k / DIV - DISCARD;
                    v = int'(adc_data) - (1 << (DATA_W - 1));
                    set_now = (adc_data == 0) || (int'(adc_data) == (1 << DATA_W) - 1);
                    if (GRP == 1) begin
                        m_vld = 1; m_out = v;
                    end else if (r % 2 == 0) begin
                        m_s0 = v;
                    end else begin
                        m_vld = 1; m_out = (m_s0 + v) >>> 1;
                    end
                end
                m_k++;
            end else begin
                m_aclk = 0;
                m_k    = 0;
            end
            if (ovr_clr && !m_set_prev) m_ovr = 0;
            if (set_now) m_ovr = 1;
            m_set_prev = set_now;
        end
    end

    always @(negedge clk) begin
        check_int("sb_vld", smp_vld, m_vld);
        check_int("sb_out", smp_out, m_out);
        check_int("sb_ovr", ovr, m_ovr);
        check_int("sb_adc_clk", adc_clk, m_aclk);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_vld(input int max, input string name, output int lat);
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!smp_vld && lat < max);
        check_int({name, "_seen"}, smp_vld, 1);
    endtask

    typedef struct {
        logic [DATA_W-1:0] code;
        int                exp_out;
        bit                exp_ovr;
    } vec_t;

    vec_t tbl[10];

    initial begin : main
        int lat, hi, lo, n, held, vld_seen, aclk_hi;

        tbl[0] = '{8'd200,   72, 1'b0};
        tbl[1] = '{8'd100,  -28, 1'b0};
        tbl[2] = '{8'd128,    0, 1'b0};
        tbl[3] = '{8'd127,   -1, 1'b0};
        tbl[4] = '{8'd129,    1, 1'b0};
        tbl[5] = '{8'd254,  126, 1'b0};
        tbl[6] = '{8'd1,   -127, 1'b0};
        tbl[7] = '{8'd255,  127, 1'b1};
        tbl[8] = '{8'd0,   -128, 1'b1};
        tbl[9] = '{8'd200,   72, 1'b1};

        rst_n = 0; en = 0; ovr_clr = 0; adc_data = 8'd200;
        repeat (3) tick();
        check_int("rst_adc_clk", adc_clk, 0);
        check_int("rst_smp_out", smp_out, 0);
        check_int("rst_smp_vld", smp_vld, 0);
        check_int("rst_ovr", ovr, 0);
        rst_n = 1;
        repeat (2) tick();

        // first enable: latency, value, strobe spacing
        en = 1;
        wait_vld(FIRST_LAT + 100, "first", lat);
        check_int("first_lat", lat, FIRST_LAT);
        check_int("first_out", smp_out, 72);
        check_int("first_ovr", ovr, 0);
        wait_vld(STRB_GAP + 20, "gap", lat);
        check_int("strobe_gap", lat, STRB_GAP);

        // adc_clk duty: measure one full high run and low run
        n = 0;
        while (!adc_clk && n < DIV) begin tick(); n++; end
        hi = 0;
        while (adc_clk && hi < DIV) begin tick(); hi++; end
        lo = 0;
        while (!adc_clk && lo < DIV) begin tick(); lo++; end
        check_int("adc_clk_high", hi, DIV / 2);
        check_int("adc_clk_low", lo, DIV - DIV / 2);

        // code conversion table, new code applied on each strobe cycle
        wait_vld(STRB_GAP + 20, "sync", lat);
        for (int i = 0; i < 10; i++) begin
            adc_data = tbl[i].code;
            wait_vld(STRB_GAP + 20, "tbl", lat);
            check_int($sformatf("tbl%0d_out", i), smp_out, tbl[i].exp_out);
            check_int($sformatf("tbl%0d_ovr", i), ovr, tbl[i].exp_ovr);
        end

        // clear on a non-rail strobe cycle
        ovr_clr = 1;
`ifndef ADC_AVG2_EN
        adc_data = 8'd128;
`else
        adc_data = 8'd200;
`endif
        tick();
        ovr_clr = 0;
        check_int("ovr_clr_first", ovr, 0);

`ifndef ADC_AVG2_EN
        wait_vld(STRB_GAP + 20, "s128", lat);
        check_int("seq128_out", smp_out, 0);
        check_int("seq128_ovr", ovr, 0);
        adc_data = 8'd0;
        wait_vld(STRB_GAP + 20, "s0", lat);
        check_int("seq0_out", smp_out, -128);
        check_int("seq0_ovr", ovr, 1);
        adc_data = 8'd255;
        wait_vld(STRB_GAP + 20, "s255", lat);
        check_int("seq255_out", smp_out, 127);
        ovr_clr = 1;
        adc_data = 8'd200;
        tick();
        ovr_clr = 0;
        check_int("ovr_set_wins", ovr, 1);
`else
        wait_vld(STRB_GAP + 20, "psync", lat);
        adc_data = 8'd200;
        repeat (DIV) tick();
        adc_data = 8'd100;
        wait_vld(STRB_GAP + 20, "pair1", lat);
        check_int("pair1_lat", lat, DIV);
        check_int("pair1_out", smp_out, 22);
        adc_data = 8'd0;
        repeat (DIV) tick();
        adc_data = 8'd1;
        wait_vld(STRB_GAP + 20, "pair2", lat);
        check_int("pair2_out", smp_out, -128);
        check_int("pair2_ovr", ovr, 1);
        adc_data = 8'd200;
`endif
        repeat (5) tick();
        ovr_clr = 1;
        tick();
        ovr_clr = 0;
        check_int("ovr_clr_alone", ovr, 0);

        // en dropped at div_cnt=30 in RUN
        wait_vld(STRB_GAP + 20, "dsync", lat);
        repeat (30) tick();
        held = smp_out;
        en = 0;
        vld_seen = 0; aclk_hi = 0;
        repeat (3 * DIV) begin
            tick();
            if (smp_vld) vld_seen++;
            if (adc_clk) aclk_hi++;
        end
        check_int("drop_no_vld", vld_seen, 0);
        check_int("drop_adc_clk", aclk_hi, 0);
        check_int("drop_hold", smp_out, held);
        en = 1;
        wait_vld(FIRST_LAT + 100, "reen", lat);
        check_int("reen_lat", lat, FIRST_LAT);

        // en dropped on the capture cycle: pending strobe suppressed
        repeat (STRB_GAP - 1) tick();
        held = smp_out;
        adc_data = 8'd10;
        en = 0;
        vld_seen = 0;
        repeat (5) begin
            tick();
            if (smp_vld) vld_seen++;
        end
        check_int("pend_no_vld", vld_seen, 0);
        check_int("pend_hold", smp_out, held);

        // asynchronous reset in the middle of RUN
        en = 1;
        adc_data = 8'd255;
        wait_vld(FIRST_LAT + 100, "prerst", lat);
        repeat (10) tick();
        check_int("prerst_ovr", ovr, 1);
        @(posedge clk);
        #3 rst_n = 0;
        #1;
        check_int("arst_adc_clk", adc_clk, 0);
        check_int("arst_smp_out", smp_out, 0);
        check_int("arst_smp_vld", smp_vld, 0);
        check_int("arst_ovr", ovr, 0);
        repeat (2) tick();
        rst_n = 1;
        wait_vld(FIRST_LAT + 100, "rec", lat);
        check_int("rec_lat", lat, FIRST_LAT);
        check_int("rec_out", smp_out, 127);

        // randomized traffic against the model
        for (int c = 0; c < 6000; c++) begin
            if ($urandom_range(0, 7) == 0)
                adc_data = ($urandom_range(0, 1) == 0) ? 8'd0 : 8'd255;
            else
                adc_data = 8'($urandom);
            ovr_clr = ($urandom_range(0, 19) == 0);
            if (en && $urandom_range(0, 399) == 0) en = 0;
            else if (!en && $urandom_range(0, 29) == 0) en = 1;
            tick();
        end
        ovr_clr = 0;
        en = 0;
        repeat (2) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
